// File: rtl/ps2_scancode_decoder_if.sv
// Key-event channel between the scan-code decoder and the keyboard consumer.
// The decoder presents the head event with key_valid; the consumer takes it
// on any cycle where it also drives key_ready high.
interface ps2_scancode_decoder_if;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_break;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_extended,
        output key_break,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_extended,
        input  key_break,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder.
// Folds E0/F0/E1 prefix bytes into single key events, separates keyboard
// status bytes, abandons stalled multi-byte sequences after a timeout, and
// queues key events in a small first-word-fall-through FIFO.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_done,
    ps2_scancode_decoder_if.master      key,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  status_code,
    output logic                        status_valid,
    output logic                        overflow,
    output logic                        timeout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [2:0]    PAUSE_LEN = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_PAUSE
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    // Keyboard responses (BAT result, echo, ack, resend, errors) are never key events.
    function automatic logic is_status(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

    // E0 12 / E0 59 are the fake-shift bytes some keys wrap themselves in.
    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    state_t          state, state_n;
    logic [2:0]      skip, skip_n;
    logic [TW-1:0]   tmo_cnt;
    logic            push;
    key_event_t      push_ev;
    logic            status_hit;
    logic            timeout_hit;

    key_event_t      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            full, pop, accept;
    key_event_t      head;

    // Sequence FSM: decides the next prefix state and whether this byte yields an event.
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_n     = state;
        skip_n      = skip;
        push        = 1'b0;
        push_ev     = '0;
        status_hit  = 1'b0;
        timeout_hit = 1'b0;

        if (rx_done) begin
            if (is_status(rx_data)) begin
                status_hit = 1'b1;
                state_n    = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        case (rx_data)
                            8'hF0:   state_n = S_BRK;
                            8'hE0:   state_n = S_EXT;
                            8'hE1: begin
                                state_n = S_PAUSE;
                                skip_n  = PAUSE_LEN;
                            end
                            default: begin
                                push    = 1'b1;
                                push_ev = '{rx_data, 1'b0, 1'b0};
                            end
                        endcase
                    end
                    S_EXT: begin
                        case (rx_data)
                            8'hE0:   state_n = S_EXT;
                            8'hF0:   state_n = S_EXTBRK;
                            8'hE1: begin
                                state_n = S_PAUSE;
                                skip_n  = PAUSE_LEN;
                            end
                            default: begin
                                state_n = S_IDLE;
                                if (!is_fake_shift(rx_data)) begin
                                    push    = 1'b1;
                                    push_ev = '{rx_data, 1'b1, 1'b0};
                                end
                            end
                        endcase
                    end
                    S_BRK: begin
                        case (rx_data)
                            8'hF0:   state_n = S_BRK;
                            8'hE0:   state_n = S_EXTBRK;
                            8'hE1: begin
                                state_n = S_PAUSE;
                                skip_n  = PAUSE_LEN;
                            end
                            default: begin
                                state_n = S_IDLE;
                                push    = 1'b1;
                                push_ev = '{rx_data, 1'b0, 1'b1};
                            end
                        endcase
                    end
                    S_EXTBRK: begin
                        case (rx_data)
                            8'hE0, 8'hF0: state_n = S_EXTBRK;
                            8'hE1: begin
                                state_n = S_PAUSE;
                                skip_n  = PAUSE_LEN;
                            end
                            default: begin
                                state_n = S_IDLE;
                                if (!is_fake_shift(rx_data)) begin
                                    push    = 1'b1;
                                    push_ev = '{rx_data, 1'b1, 1'b1};
                                end
                            end
                        endcase
                    end
                    S_PAUSE: begin
                        // Pause sends no break code; its remaining bytes are only counted off.
                        skip_n = skip - 3'd1;
                        if (skip == 3'd1) begin
                            state_n = S_IDLE;
                            push    = 1'b1;
                            push_ev = '{8'h77, 1'b1, 1'b0};
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end else if ((state != S_IDLE) && (tmo_cnt == TMO_LAST)) begin
            state_n     = S_IDLE;
            timeout_hit = 1'b1;
        end
    end

    // FSM state and pause byte counter.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            skip  <= '0;
        end else begin
            state <= state_n;
            skip  <= skip_n;
        end
    end

    // Inter-byte timer: runs only while a sequence is partially received.
    always_ff @(posedge clk) begin
        if (reset || rx_done || (state_n == S_IDLE)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Status byte capture and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_code  <= '0;
            status_valid <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            if (status_hit) begin
                status_code <= rx_data;
            end
            status_valid <= status_hit;
            overflow     <= push & full & ~pop;
            timeout      <= timeout_hit;
        end
    end

    assign full          = (fifo_count == CNT_FULL);
    assign key.key_valid = (fifo_count != '0);
    assign pop           = key.key_valid & key.key_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept        = push & (~full | pop);

    // Event storage write port.
    // NOTE: the storage array has no reset; empty slots are never observable because the head is gated by key_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_ev;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head             = mem[rd_ptr];
    assign key.key_code     = key.key_valid ? head.code : 8'h00;
    assign key.key_extended = key.key_valid & head.ext;
    assign key.key_break    = key.key_valid & head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed sequences followed by
// randomized byte streams and random consumer back-pressure. A prefix-flag
// reference model predicts events, which a negedge monitor compares as the
// DUT hands them over.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [2:0]  fifo_count;
    logic [7:0]  status_code;
    logic        status_valid;
    logic        overflow;
    logic        timeout;

    ps2_scancode_decoder_if kif ();

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .key          (kif),
        .fifo_count   (fifo_count),
        .status_code  (status_code),
        .status_valid (status_valid),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pending prefixes as plain flags plus a pause byte budget.
    bit          m_ext;
    bit          m_brk;
    int          m_pause;
    int          cyc = 0;
    int          last_cyc = 0;
    logic [9:0]  exp_q [$];
    logic [7:0]  exp_st [$];
    int          exp_ovf = 0;
    int          exp_tmo = 0;
    int          seen_ovf = 0;
    int          seen_tmo = 0;
    bit          rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_partial();
        return m_ext || m_brk || (m_pause > 0);
    endfunction

    task automatic m_clear();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
    endtask

    // A partial sequence is abandoned when more than TMO cycles separate two bytes.
    task automatic m_timeout_check();
        if (m_partial() && ((cyc - last_cyc) > TMO)) begin
            m_clear();
            exp_tmo++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit has_ev, output logic [9:0] ev);
        has_ev = 1'b0;
        ev     = '0;
        if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
            exp_st.push_back(b);
            m_clear();
        end else if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin
                has_ev = 1'b1;
                ev     = {8'h77, 1'b1, 1'b0};
            end
        end else if (b == 8'hE1) begin
            m_clear();
            m_pause = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!(m_ext && (b == 8'h12 || b == 8'h59))) begin
                has_ev = 1'b1;
                ev     = {b, m_ext, m_brk};
            end
            m_clear();
        end
    endtask

    // Drive one rx_done strobe; called at posedge+1, returns at the next posedge+1.
    task automatic send_byte(input logic [7:0] b);
        bit         has;
        logic [9:0] ev;
        bit         pop_now;
        if (rand_ready) kif.key_ready = 1'($urandom_range(0, 1));
        m_timeout_check();
        model_byte(b, has, ev);
        if (has) begin
            pop_now = kif.key_ready && (exp_q.size() > 0);
            if ((exp_q.size() == DEPTH) && !pop_now) exp_ovf++;
            else exp_q.push_back(ev);
        end
        last_cyc = cyc;
        rx_data  = b;
        rx_done  = 1'b1;
        @(posedge clk);
        #1;
        rx_done  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_ready) kif.key_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every handed-over event and status pulse against the model queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (kif.key_valid && kif.key_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_event: got %0h, expected no event", {kif.key_code, kif.key_extended, kif.key_break});
                end else begin
                    check("event", {22'd0, kif.key_code, kif.key_extended, kif.key_break}, {22'd0, exp_q.pop_front()});
                end
            end
            if (status_valid) begin
                if (exp_st.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_status: got %0h, expected no status", status_code);
                end else begin
                    check("status_code", {24'd0, status_code}, {24'd0, exp_st.pop_front()});
                end
            end
            if (overflow) seen_ovf++;
            if (timeout)  seen_tmo++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] seq [$];

    initial begin
        m_clear();
        kif.key_ready = 1'b0;
        // rx_done during reset must be ignored.
        rx_data = 8'h1C;
        rx_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx_done = 1'b0;
        reset   = 1'b0;
        last_cyc = cyc;
        check("reset_key_valid",    {31'd0, kif.key_valid}, 32'd0);
        check("reset_fifo_count",   {29'd0, fifo_count}, 32'd0);
        check("reset_key_code",     {24'd0, kif.key_code}, 32'd0);
        check("reset_key_flags",    {30'd0, kif.key_extended, kif.key_break}, 32'd0);
        check("reset_status_code",  {24'd0, status_code}, 32'd0);
        check("reset_pulses",       {29'd0, status_valid, overflow, timeout}, 32'd0);

        // Make / break with one-cycle latency.
        kif.key_ready = 1'b1;
        send_byte(8'h1C);
        check("make_latency_valid", {31'd0, kif.key_valid}, 32'd1);
        check("make_head_code",     {24'd0, kif.key_code}, 32'h1C);
        send_byte(8'hF0);
        check("break_prefix_no_valid", {31'd0, kif.key_valid}, 32'd0);
        send_byte(8'h1C);
        check("break_latency_valid", {31'd0, kif.key_valid}, 32'd1);
        check("break_head_flag",     {31'd0, kif.key_break}, 32'd1);
        idle(3);

        // Extended keys and print-screen fake shift.
        seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'hE0, 8'h75, 8'hE0, 8'h12, 8'hE0, 8'h7C};
        foreach (seq[i]) send_byte(seq[i]);
        idle(4);

        // Pause: one event on the eighth byte.
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
        foreach (seq[i]) send_byte(seq[i]);
        check("pause_not_early", {31'd0, kif.key_valid}, 32'd0);
        send_byte(8'h77);
        check("pause_valid", {31'd0, kif.key_valid}, 32'd1);
        check("pause_head",  {22'd0, kif.key_code, kif.key_extended, kif.key_break}, {22'd0, 8'h77, 2'b10});
        idle(3);

        // Status bytes in IDLE and mid-sequence.
        send_byte(8'hAA);
        check("status_pulse", {31'd0, status_valid}, 32'd1);
        check("status_no_event", {31'd0, kif.key_valid}, 32'd0);
        send_byte(8'hE0);
        send_byte(8'hFA);
        send_byte(8'h1C);
        idle(3);

        // Overflow with the consumer stalled.
        kif.key_ready = 1'b0;
        seq = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        foreach (seq[i]) send_byte(seq[i]);
        idle(1);
        check("ovf_fifo_count", {29'd0, fifo_count}, 32'd4);
        check("ovf_pulses",     seen_ovf, exp_ovf);
        kif.key_ready = 1'b1;
        idle(6);
        check("ovf_drained", {29'd0, fifo_count}, 32'd0);

        // Full FIFO with push and pop in the same cycle.
        kif.key_ready = 1'b0;
        seq = '{8'h15, 8'h16, 8'h1E, 8'h26};
        foreach (seq[i]) send_byte(seq[i]);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        kif.key_ready = 1'b1;
        send_byte(8'h25);
        kif.key_ready = 1'b0;
        check("full_pushpop_count", {29'd0, fifo_count}, 32'd4);
        idle(1);
        check("full_pushpop_no_ovf", seen_ovf, exp_ovf);
        kif.key_ready = 1'b1;
        idle(6);

        // Count one with push and pop in the same cycle.
        kif.key_ready = 1'b0;
        send_byte(8'h15);
        kif.key_ready = 1'b1;
        send_byte(8'h16);
        check("one_pushpop_valid", {31'd0, kif.key_valid}, 32'd1);
        check("one_pushpop_head",  {24'd0, kif.key_code}, 32'h16);
        idle(3);

        // Timeout boundary: a gap of exactly TMO cycles survives, one more abandons.
        send_byte(8'hF0);
        idle(TMO - 1);
        send_byte(8'h1C);
        send_byte(8'hF0);
        idle(TMO);
        send_byte(8'h1C);
        idle(3);
        check("timeout_pulses", seen_tmo, exp_tmo);

        // Reset mid-sequence with entries queued.
        kif.key_ready = 1'b0;
        send_byte(8'h15);
        send_byte(8'h16);
        send_byte(8'hE0);
        check("pre_reset_count", {29'd0, fifo_count}, 32'd2);
        m_timeout_check();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_clear();
        last_cyc = cyc;
        check("midreset_valid", {31'd0, kif.key_valid}, 32'd0);
        check("midreset_count", {29'd0, fifo_count}, 32'd0);
        kif.key_ready = 1'b1;
        send_byte(8'h1C);
        check("post_reset_head", {22'd0, kif.key_code, kif.key_extended, kif.key_break}, {22'd0, 8'h1C, 2'b00});
        idle(3);

        // Randomized streams with random back-pressure.
        rand_ready = 1'b1;
        repeat (400) begin
            logic [7:0] b;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 12)      b = 8'hE0;
            else if (sel < 24) b = 8'hF0;
            else if (sel < 29) b = 8'hE1;
            else if (sel < 34) b = (sel < 32) ? 8'h12 : 8'h59;
            else if (sel < 38) b = (sel < 36) ? 8'hAA : 8'hFA;
            else               b = 8'($urandom_range(1, 8'h83));
            send_byte(b);
            if ($urandom_range(0, 11) == 0) idle(int'($urandom_range(TMO - 2, TMO + 3)));
            else                            idle(int'($urandom_range(0, 2)));
        end
        rand_ready    = 1'b0;
        kif.key_ready = 1'b1;
        idle(TMO + 4);
        m_timeout_check();
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
        check("drain_events",  exp_q.size(), 0);
        check("drain_status",  exp_st.size(), 0);
        check("total_overflow", seen_ovf, exp_ovf);
        check("total_timeout",  seen_tmo, exp_tmo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
